// File: rtl/motor_cmd_scheduler_pkg.sv
// Shared constants for the motor command scheduler: frame header, direction codes,
// parser and channel state encodings, and the frame validity check.
package motor_cmd_scheduler_pkg;

  localparam logic [7:0] HDR      = 8'hA5;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;
  localparam logic [1:0] DIR_BAD  = 2'b11;

  localparam logic [1:0] P_HUNT   = 2'd0;
  localparam logic [1:0] P_CMD    = 2'd1;
  localparam logic [1:0] P_DUTY   = 2'd2;
  localparam logic [1:0] P_CSUM   = 2'd3;

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_RUN    = 2'd1;
  localparam logic [1:0] C_GAP    = 2'd2;

  // A frame is usable only if the checksum matches and the direction is not the reserved code.
  function automatic logic frame_ok(input logic [7:0] cmd, input logic [7:0] duty,
                                    input logic [7:0] csum);
    return (csum == (cmd ^ duty)) && (cmd[2:1] != DIR_BAD);
  endfunction

endpackage

// File: rtl/motor_chan_slot.sv
// One motor channel: IDLE -> RUN -> GAP sequencing of the pwm Start/Done handshake,
// with a one-deep pending command slot; drop_o pulses when a command is discarded.
module motor_chan_slot
  import motor_cmd_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       accept_i,
  input  logic [1:0] dir_i,
  input  logic [7:0] duty_i,
  input  logic       done_i,
  output logic       start_en_o,
  output logic [1:0] dir_o,
  output logic [7:0] duty_o,
  output logic       busy_o,
  output logic       drop_o
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [7:0]    duty_q, duty_d;
  logic          pend_vld_q, pend_vld_d;
  logic [1:0]    pend_dir_q, pend_dir_d;
  logic [7:0]    pend_duty_q, pend_duty_d;
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    duty_d      = duty_q;
    pend_vld_d  = pend_vld_q;
    pend_dir_d  = pend_dir_q;
    pend_duty_d = pend_duty_q;
    gap_d       = gap_q;
    drop_o      = 1'b0;

    case (state_q)
      C_IDLE: begin
        if (pend_vld_q) begin
          state_d    = C_RUN;
          dir_d      = pend_dir_q;
          duty_d     = pend_duty_q;
          pend_vld_d = 1'b0;
          drop_o     = accept_i;
        end else if (accept_i) begin
          state_d = C_RUN;
          dir_d   = dir_i;
          duty_d  = duty_i;
        end
      end
      C_RUN: begin
        if (accept_i) begin
          if (pend_vld_q) begin
            drop_o = 1'b1;
          end else begin
            pend_vld_d  = 1'b1;
            pend_dir_d  = dir_i;
            pend_duty_d = duty_i;
          end
        end
        if (done_i) begin
          state_d = C_GAP;
          gap_d   = '0;
        end
      end
      C_GAP: begin
        // Last low cycle launches the next command directly so the gap is exactly GAP_CYCLES.
        if (gap_q == GAP_LAST) begin
          if (pend_vld_q) begin
            state_d    = C_RUN;
            dir_d      = pend_dir_q;
            duty_d     = pend_duty_q;
            pend_vld_d = 1'b0;
            drop_o     = accept_i;
          end else if (accept_i) begin
            state_d = C_RUN;
            dir_d   = dir_i;
            duty_d  = duty_i;
          end else begin
            state_d = C_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
          if (accept_i) begin
            if (pend_vld_q) begin
              drop_o = 1'b1;
            end else begin
              pend_vld_d  = 1'b1;
              pend_dir_d  = dir_i;
              pend_duty_d = duty_i;
            end
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= C_IDLE;
      dir_q       <= DIR_STOP;
      duty_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_dir_q  <= DIR_STOP;
      pend_duty_q <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      pend_vld_q  <= pend_vld_d;
      pend_dir_q  <= pend_dir_d;
      pend_duty_q <= pend_duty_d;
      gap_q       <= gap_d;
    end
  end

  assign start_en_o = (state_q == C_RUN);
  assign dir_o      = dir_q;
  assign duty_o     = duty_q;
  assign busy_o     = (state_q != C_IDLE) || pend_vld_q;

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Decodes A5/CMD/DUTY/CSUM frames from the UART byte stream and dispatches them
// to two motor channel slots; counts bad frames, timeouts and dropped commands.
module motor_cmd_scheduler
  import motor_cmd_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 49152,
  parameter int GAP_CYCLES     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] RxData,
  input  logic       Rx_Done_Sig,
  input  logic       M1_Done_Sig,
  input  logic       M2_Done_Sig,
  output logic       M1_Start_En_Sig,
  output logic [1:0] M1_Dir,
  output logic [7:0] M1_Duty,
  output logic       M2_Start_En_Sig,
  output logic [1:0] M2_Dir,
  output logic [7:0] M2_Duty,
  output logic       busy,
  output logic [7:0] frame_err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    pst_q, pst_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    duty_q, duty_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    err_q, err_d;
  logic          accept, frame_err;
  logic          m1_busy, m2_busy, m1_drop, m2_drop;
  logic [1:0]    err_inc;
  logic [8:0]    err_sum;

  always_comb begin
    pst_d     = pst_q;
    cmd_d     = cmd_q;
    duty_d    = duty_q;
    tmo_d     = tmo_q;
    accept    = 1'b0;
    frame_err = 1'b0;

    if (Rx_Done_Sig) begin
      tmo_d = '0;
      case (pst_q)
        P_HUNT: if (RxData == HDR) pst_d = P_CMD;
        P_CMD: begin
          cmd_d = RxData;
          pst_d = P_DUTY;
        end
        P_DUTY: begin
          duty_d = RxData;
          pst_d  = P_CSUM;
        end
        default: begin
          pst_d = P_HUNT;
          if (frame_ok(cmd_q, duty_q, RxData)) accept = 1'b1;
          else                                  frame_err = 1'b1;
        end
      endcase
    end else if (pst_q != P_HUNT) begin
      // Inter-byte silence inside a frame abandons it.
      if (tmo_q == TMO_LAST) begin
        tmo_d     = '0;
        pst_d     = P_HUNT;
        frame_err = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign err_inc = {1'b0, frame_err} + {1'b0, m1_drop} + {1'b0, m2_drop};
  assign err_sum = {1'b0, err_q} + {7'b0, err_inc};
  assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pst_q  <= P_HUNT;
      cmd_q  <= '0;
      duty_q <= '0;
      tmo_q  <= '0;
      err_q  <= '0;
    end else begin
      pst_q  <= pst_d;
      cmd_q  <= cmd_d;
      duty_q <= duty_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
    end
  end

  motor_chan_slot #(.GAP_CYCLES(GAP_CYCLES)) u_m1 (
    .clk        (clk),
    .reset      (reset),
    .accept_i   (accept & ~cmd_q[0]),
    .dir_i      (cmd_q[2:1]),
    .duty_i     (duty_q),
    .done_i     (M1_Done_Sig),
    .start_en_o (M1_Start_En_Sig),
    .dir_o      (M1_Dir),
    .duty_o     (M1_Duty),
    .busy_o     (m1_busy),
    .drop_o     (m1_drop)
  );

  motor_chan_slot #(.GAP_CYCLES(GAP_CYCLES)) u_m2 (
    .clk        (clk),
    .reset      (reset),
    .accept_i   (accept & cmd_q[0]),
    .dir_i      (cmd_q[2:1]),
    .duty_i     (duty_q),
    .done_i     (M2_Done_Sig),
    .start_en_o (M2_Start_En_Sig),
    .dir_o      (M2_Dir),
    .duty_o     (M2_Duty),
    .busy_o     (m2_busy),
    .drop_o     (m2_drop)
  );

  assign busy          = m1_busy | m2_busy;
  assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler: frames, queueing, errors, timeout, reset, saturation.
module tb_motor_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] RxData = 8'h00;
  logic       Rx_Done_Sig = 1'b0;
  logic       M1_Done_Sig = 1'b0;
  logic       M2_Done_Sig = 1'b0;
  logic       M1_Start_En_Sig, M2_Start_En_Sig, busy;
  logic [1:0] M1_Dir, M2_Dir;
  logic [7:0] M1_Duty, M2_Duty, frame_err_cnt;

  int n_checks = 0;
  int n_errs   = 0;
  int exp_err  = 0;

  motor_cmd_scheduler #(.TIMEOUT_CYCLES(49152), .GAP_CYCLES(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .RxData          (RxData),
    .Rx_Done_Sig     (Rx_Done_Sig),
    .M1_Done_Sig     (M1_Done_Sig),
    .M2_Done_Sig     (M2_Done_Sig),
    .M1_Start_En_Sig (M1_Start_En_Sig),
    .M1_Dir          (M1_Dir),
    .M1_Duty         (M1_Duty),
    .M2_Start_En_Sig (M2_Start_En_Sig),
    .M2_Dir          (M2_Dir),
    .M2_Duty         (M2_Duty),
    .busy            (busy),
    .frame_err_cnt   (frame_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RxData      = b;
    Rx_Done_Sig = 1'b1;
    @(negedge clk);
    Rx_Done_Sig = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic done1();
    M1_Done_Sig = 1'b1;
    @(negedge clk);
    M1_Done_Sig = 1'b0;
  endtask

  task automatic done2();
    M2_Done_Sig = 1'b1;
    @(negedge clk);
    M2_Done_Sig = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_m1_start", M1_Start_En_Sig, 0);
    check("rst_m1_dir", M1_Dir, 0);
    check("rst_m2_start", M2_Start_En_Sig, 0);
    check("rst_busy", busy, 0);
    check("rst_err", frame_err_cnt, 0);
    reset = 1'b0;
    tick(2);

    // CMD bit0 selects the motor (0 = M1), bits 2:1 the direction.
    send_frame(8'hA5, 8'h02, 8'h40, 8'h42);
    check("t1_m1_start", M1_Start_En_Sig, 1);
    check("t1_m1_dir", M1_Dir, 2'b01);
    check("t1_m1_duty", M1_Duty, 8'h40);
    check("t1_m2_idle", M2_Start_En_Sig, 0);
    check("t1_busy", busy, 1);
    tick(3);
    check("t1_hold", M1_Start_En_Sig, 1);
    done1();
    check("t1_low_after_done", M1_Start_En_Sig, 0);
    check("t1_dir_kept", M1_Dir, 2'b01);
    check("t1_busy_gap", busy, 1);
    tick();
    check("t1_idle", busy, 0);
    done1();
    check("t1_done_in_idle", M1_Start_En_Sig, 0);
    check("t1_done_in_idle_busy", busy, 0);

    send_frame(8'hA5, 8'h02, 8'h40, 8'h42);
    send_frame(8'hA5, 8'h05, 8'h80, 8'h85);
    check("t2_m2_start", M2_Start_En_Sig, 1);
    check("t2_m2_dir", M2_Dir, 2'b10);
    check("t2_m2_duty", M2_Duty, 8'h80);
    check("t2_m1_start", M1_Start_En_Sig, 1);
    check("t2_m1_duty", M1_Duty, 8'h40);
    done1();
    done2();
    tick();
    check("t2_idle", busy, 0);

    send_frame(8'hA5, 8'h02, 8'h40, 8'h42);
    send_frame(8'hA5, 8'h04, 8'h20, 8'h24);
    send_frame(8'hA5, 8'h02, 8'h11, 8'h13);
    exp_err = 1;
    check("t3_err_drop", frame_err_cnt, exp_err);
    check("t3_first_running", M1_Duty, 8'h40);
    done1();
    check("t3_gap_low", M1_Start_En_Sig, 0);
    tick();
    check("t3_pending_start", M1_Start_En_Sig, 1);
    check("t3_pending_dir", M1_Dir, 2'b10);
    check("t3_pending_duty", M1_Duty, 8'h20);
    done1();
    tick();
    check("t3_idle", busy, 0);

    send_frame(8'hA5, 8'h02, 8'h40, 8'h00);
    exp_err++;
    check("t4_bad_csum_err", frame_err_cnt, exp_err);
    check("t4_bad_csum_nostart", M1_Start_En_Sig, 0);
    send_frame(8'hA5, 8'h07, 8'h10, 8'h17);
    exp_err++;
    check("t4_dir11_err", frame_err_cnt, exp_err);
    check("t4_dir11_nostart", M2_Start_En_Sig, 0);
    send_byte(8'h12);
    send_frame(8'hA5, 8'h02, 8'h33, 8'h31);
    check("t4_resync_start", M1_Start_En_Sig, 1);
    check("t4_resync_duty", M1_Duty, 8'h33);
    check("t4_hunt_no_err", frame_err_cnt, exp_err);
    done1();
    tick();
    send_frame(8'hA5, 8'h04, 8'hA5, 8'hA1);
    check("t4_a5_as_duty", M1_Duty, 8'hA5);
    check("t4_a5_dir", M1_Dir, 2'b10);
    done1();
    tick();

    send_byte(8'hA5);
    send_byte(8'h02);
    tick(49142);
    check("t5_before_timeout", frame_err_cnt, exp_err);
    tick(20);
    exp_err++;
    check("t5_timeout_err", frame_err_cnt, exp_err);
    send_frame(8'hA5, 8'h02, 8'h40, 8'h42);
    check("t5_after_timeout_start", M1_Start_En_Sig, 1);
    check("t5_after_timeout_duty", M1_Duty, 8'h40);

    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h20);
    RxData      = 8'h24;
    Rx_Done_Sig = 1'b1;
    M1_Done_Sig = 1'b1;
    tick();
    Rx_Done_Sig = 1'b0;
    M1_Done_Sig = 1'b0;
    check("t6_coincident_low", M1_Start_En_Sig, 0);
    tick();
    check("t6_coincident_restart", M1_Start_En_Sig, 1);
    check("t6_coincident_duty", M1_Duty, 8'h20);
    check("t6_no_drop", frame_err_cnt, exp_err);

    send_frame(8'hA5, 8'h05, 8'h80, 8'h85);
    reset = 1'b1;
    tick();
    check("t6_rst_m1_start", M1_Start_En_Sig, 0);
    check("t6_rst_m2_start", M2_Start_En_Sig, 0);
    check("t6_rst_m2_duty", M2_Duty, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", frame_err_cnt, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 254; i++) send_frame(8'hA5, 8'h02, 8'h40, 8'h00);
    check("t6_err_254", frame_err_cnt, 8'hFE);
    for (int i = 0; i < 46; i++) send_frame(8'hA5, 8'h02, 8'h40, 8'h00);
    check("t6_err_sat", frame_err_cnt, 8'hFF);
    check("t6_sat_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
